// File: rtl/clk_edge_sync.sv
// clk_edge_sync: samples a divided clock as data, emits edge ticks, measures
// the rise-to-rise period and tracks IDLE/ACQUIRE/LOCKED/LOST.
module clk_edge_sync #(
    parameter int unsigned TIMEOUT    = 512,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        slow_clk,
    input  logic        active,
    output logic        rise_tick,
    output logic        fall_tick,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        locked,
    output logic        lost
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_e;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);
    localparam logic [3:0]  LC     = 4'(LOCK_COUNT);

    state_e      state_q, state_d;
    logic        sync1_q, sync2_q, hist_q;
    logic [2:0]  prime_q;
    logic        rise_det, fall_det, rise_ev, fall_ev, meas, timeout;
    logic [31:0] cnt_q, cnt_d, period_q, period_d;
    logic [15:0] to_q, to_d;
    logic [3:0]  match_q, match_d;
    logic        have_ref_q, have_ref_d;
    logic        rise_q, fall_q, pv_q;

    // Two-flop synchronizer plus history flop; prime_q marks when the history
    // flop holds a real post-reset sample so reset release can't fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            prime_q <= '0;
        end else begin
            sync1_q <= slow_clk;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            prime_q <= {prime_q[1:0], 1'b1};
        end
    end

    assign rise_det = prime_q[2] & sync2_q & ~hist_q;
    assign fall_det = prime_q[2] & ~sync2_q & hist_q;
    assign rise_ev  = rise_det & active & (state_q != IDLE);
    assign fall_ev  = fall_det & active & (state_q != IDLE);
    assign meas     = rise_ev & have_ref_q;
    assign timeout  = (to_q >= TO_LIM);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: deactivation beats everything, a rise beats a timeout
    always_comb begin
        state_d = state_q;
        if (!active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ACQUIRE;
                ACQUIRE: begin
                    if (rise_ev)             state_d = ACQUIRE;
                    else if (timeout)        state_d = LOST;
                    else if (match_q >= LC)  state_d = LOCKED;
                end
                LOCKED: begin
                    if (rise_ev) begin
                        if (meas && cnt_q != period_q) state_d = ACQUIRE;
                    end else if (timeout) begin
                        state_d = LOST;
                    end
                end
                LOST:    if (rise_ev) state_d = ACQUIRE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Status outputs decoded straight from the state register
    always_comb begin
        locked = (state_q == LOCKED);
        lost   = (state_q == LOST);
    end

    // Datapath next values: interval counter, timeout counter, match tracking
    always_comb begin
        cnt_d      = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        to_d       = (to_q < TO_LIM) ? to_q + 16'd1 : to_q;
        period_d   = period_q;
        match_d    = match_q;
        have_ref_d = have_ref_q;
        if (!active) begin
            cnt_d      = '0;
            to_d       = '0;
            period_d   = '0;
            match_d    = '0;
            have_ref_d = 1'b0;
        end else if (state_q == IDLE) begin
            // Entering ACQUIRE: timeout window starts now, no reference rise yet
            cnt_d      = '0;
            to_d       = 16'd1;
            match_d    = '0;
            have_ref_d = 1'b0;
        end else if (rise_ev) begin
            cnt_d      = 32'd1;
            to_d       = 16'd1;
            have_ref_d = 1'b1;
            if (meas) begin
                period_d = cnt_q;
                if (match_q != 4'd0 && cnt_q == period_q)
                    match_d = (match_q == 4'hF) ? match_q : match_q + 4'd1;
                else
                    match_d = 4'd1;
            end
        end else if (state_d == LOST && state_q != LOST) begin
            // Next rise after loss only re-establishes the reference
            match_d    = '0;
            have_ref_d = 1'b0;
        end
    end

    // Datapath and tick registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            to_q       <= '0;
            period_q   <= '0;
            match_q    <= '0;
            have_ref_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            pv_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            period_q   <= period_d;
            match_q    <= match_d;
            have_ref_q <= have_ref_d;
            rise_q     <= rise_ev;
            fall_q     <= fall_ev;
            pv_q       <= meas;
        end
    end

    assign rise_tick    = rise_q;
    assign fall_tick    = fall_q;
    assign period       = period_q;
    assign period_valid = pv_q;

endmodule

// File: tb/tb_clk_edge_sync.sv
// Bench for clk_edge_sync: directed scenarios plus randomized slow clocks,
// checked every cycle against an event-time reference model.
module tb_clk_edge_sync;

    localparam int TIMEOUT    = 512;
    localparam int LOCK_COUNT = 4;

    logic        clk = 1'b0, rst_n = 1'b0, slow_clk = 1'b0, active = 1'b0;
    logic        rise_tick, fall_tick, period_valid, locked, lost;
    logic [31:0] period;

    clk_edge_sync #(.TIMEOUT(TIMEOUT), .LOCK_COUNT(LOCK_COUNT)) dut (
        .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .active(active),
        .rise_tick(rise_tick), .fall_tick(fall_tick), .period(period),
        .period_valid(period_valid), .locked(locked), .lost(lost)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    // Reference model: works on posedge indices and sample history
    typedef enum {M_IDLE, M_ACQ, M_LOCK, M_LOST} mst_e;
    mst_e m_st;
    int   n, last_rise, ref_cyc, m_per, match;
    bit   have_ref, e_rise, e_fall, e_pv;
    bit   smp[$];

    // Slow clock generator
    bit gen_on = 1'b0;
    int half = 101, ph = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = M_IDLE; n = 0; smp.delete();
        m_per = 0; match = 0; have_ref = 0;
        e_rise = 0; e_fall = 0; e_pv = 0;
        last_rise = 0; ref_cyc = 0;
    endfunction

    // One posedge of the model. A level first sampled at posedge k ticks at k+2,
    // and only if the posedge k-1 sample (taken after reset) differs.
    function automatic void model_step();
        bit r, f;
        int p;
        smp.push_back(slow_clk);
        if (smp.size() > 4) void'(smp.pop_front());
        r = (smp.size() == 4) && smp[1] && !smp[0];
        f = (smp.size() == 4) && !smp[1] && smp[0];
        e_rise = r && active && (m_st != M_IDLE);
        e_fall = f && active && (m_st != M_IDLE);
        e_pv   = 0;
        if (!active) begin
            m_st = M_IDLE; m_per = 0; match = 0; have_ref = 0;
        end else if (m_st == M_IDLE) begin
            m_st = M_ACQ; ref_cyc = n; have_ref = 0; match = 0;
        end else if (e_rise) begin
            if (m_st == M_LOST) begin
                m_st = M_ACQ;
            end else if (have_ref) begin
                p = n - last_rise;
                e_pv = 1;
                if (m_st == M_LOCK) begin
                    if (p != m_per) begin m_st = M_ACQ; match = 1; end
                end else begin
                    match = (match > 0 && p == m_per) ? match + 1 : 1;
                end
                m_per = p;
            end
            have_ref = 1; last_rise = n; ref_cyc = n;
        end else if (m_st != M_LOST && n - ref_cyc >= TIMEOUT) begin
            m_st = M_LOST; have_ref = 0; match = 0;
        end else if (m_st == M_ACQ && match >= LOCK_COUNT) begin
            m_st = M_LOCK;
        end
        n++;
    endfunction

    // One clock: model on posedge, compare on negedge, then move the slow clock
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        chk("rise_tick", {31'd0, rise_tick}, {31'd0, e_rise});
        chk("fall_tick", {31'd0, fall_tick}, {31'd0, e_fall});
        chk("period_valid", {31'd0, period_valid}, {31'd0, e_pv});
        chk("period", period, m_per);
        chk("locked", {31'd0, locked}, {31'd0, m_st == M_LOCK});
        chk("lost", {31'd0, lost}, {31'd0, m_st == M_LOST});
        if (gen_on) begin
            ph++;
            if (ph >= half) begin slow_clk = ~slow_clk; ph = 0; end
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cyc();
    endtask

    // Run until the generator drives slow_clk high; bounded
    task automatic run_to_rise(input int bound);
        bit prev, hit;
        hit = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            prev = slow_clk;
            cyc();
            if (!prev && slow_clk) hit = 1;
        end
        chk("rise_wait_bound", {31'd0, hit}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rise"}, {31'd0, rise_tick}, 32'd0);
        chk({tag, "_fall"}, {31'd0, fall_tick}, 32'd0);
        chk({tag, "_pv"}, {31'd0, period_valid}, 32'd0);
        chk({tag, "_period"}, period, 32'd0);
        chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
        chk({tag, "_lost"}, {31'd0, lost}, 32'd0);
    endtask

    initial begin
        model_reset();
        // Reset state, with slow_clk high across release
        slow_clk = 1'b1;
        #12;
        check_all_zero("reset");
        active = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run(40);
        chk("no_tick_after_release_locked", {31'd0, locked}, 32'd0);

        // Steady 202-cycle slow clock, lock after fifth rise
        half = 101; ph = 0; gen_on = 1'b1;
        run(1500);
        chk("lock202_locked", {31'd0, locked}, 32'd1);
        chk("lock202_period", period, 32'd202);

        // Stall: LOST exactly TIMEOUT cycles after last rise, period retained
        gen_on = 1'b0;
        run(700);
        chk("stall_lost", {31'd0, lost}, 32'd1);
        chk("stall_locked", {31'd0, locked}, 32'd0);
        chk("stall_period", period, 32'd202);

        // Resume and relock
        gen_on = 1'b1;
        run(1500);
        chk("relock202", {31'd0, locked}, 32'd1);

        // Period change to 150 from LOCKED
        run_to_rise(400);
        half = 75;
        run(160);
        chk("p150_unlocked", {31'd0, locked}, 32'd0);
        chk("p150_period", period, 32'd150);
        run(700);
        chk("p150_relock", {31'd0, locked}, 32'd1);

        // Drop active while acquiring
        half = 90;
        run_to_rise(400);
        run(200);
        active = 1'b0;
        cyc();
        chk("drop_period", period, 32'd0);
        chk("drop_locked", {31'd0, locked}, 32'd0);
        chk("drop_lost", {31'd0, lost}, 32'd0);
        run(3);
        active = 1'b1;

        // 512-cycle period: each rise lands on the timeout-expiry cycle
        half = 256; ph = 0;
        run(3600);
        chk("p512_lost", {31'd0, lost}, 32'd0);
        chk("p512_locked", {31'd0, locked}, 32'd1);
        chk("p512_period", period, 32'd512);

        // Randomized segments: period jumps, stalls, glitches, enable drops
        for (int s = 0; s < 14; s++) begin
            int len;
            half = $urandom_range(2, 280);
            ph = 0;
            gen_on = ($urandom_range(0, 4) != 0);
            len = $urandom_range(200, 1200);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 499) == 0) active = 1'b0;
                else if (!active && $urandom_range(0, 3) == 0) active = 1'b1;
                if ($urandom_range(0, 399) == 0) slow_clk = ~slow_clk;
                cyc();
            end
            active = 1'b1;
        end

        // Asynchronous reset between edges while LOCKED
        half = 101; ph = 0; gen_on = 1'b1;
        run(1600);
        chk("pre_async_locked", {31'd0, locked}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
